// File: rtl/ic_ram_ctrl_if.sv
// ---------------------------------------------------------------------------
// ic_ram_ctrl_if
//   Request/response bus between an interconnect initiator and the RAM target.
//
//   Request channel : req, wen, strb, wdata, addr   (initiator -> target)
//                     gnt                           (target -> initiator)
//   Response channel: recv, error, rdata            (target -> initiator)
//                     ack                           (initiator -> target)
//
//   A request transfers on a cycle with req && gnt; a response transfers on a
//   cycle with recv && ack.
// ---------------------------------------------------------------------------
interface ic_ram_ctrl_if;
  logic        req;
  logic        wen;
  logic [3:0]  strb;
  logic [31:0] wdata;
  logic [31:0] addr;
  logic        gnt;
  logic        recv;
  logic        ack;
  logic        error;
  logic [31:0] rdata;

  modport master (
    output req, wen, strb, wdata, addr, ack,
    input  gnt, recv, error, rdata
  );

  modport slave (
    input  req, wen, strb, wdata, addr, ack,
    output gnt, recv, error, rdata
  );
endinterface

// File: rtl/ic_ram_ctrl.sv
// ---------------------------------------------------------------------------
// ic_ram_ctrl
//   Memory-side target for the RAM port of the interconnect. Requests on the
//   bus are turned into single-cycle accesses of a synchronous SRAM macro with
//   1-cycle read latency. Responses are queued in a small FIFO and returned in
//   acceptance order until the initiator acks them. Up to RSP_DEPTH requests
//   may be outstanding; gnt is withheld once all response slots are claimed.
//
//   Ports
//     g_clk, g_resetn  clock, synchronous active-low reset
//     bus              request/response bus (slave side)
//     sram_cen         SRAM chip enable (active high)
//     sram_wen         SRAM write enable (active high)
//     sram_bwe         SRAM byte write enables
//     sram_addr        SRAM word address
//     sram_wdata       SRAM write data
//     sram_rdata       SRAM read data, valid the cycle after a read access
// ---------------------------------------------------------------------------
module ic_ram_ctrl #(
  parameter logic [31:0] MEM_BASE  = 32'h2000_0000,
  parameter logic [31:0] MEM_SIZE  = 32'h0001_0000,
  parameter int          AW        = 14,
  parameter int          RSP_DEPTH = 2
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  ic_ram_ctrl_if.slave      bus,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [3:0]        sram_bwe,
  output logic [AW-1:0]     sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = PW + 1;

  // Access stage: RD_PEND marks the cycle in which the SRAM (or the decode
  // error) result of the previous accept becomes available.
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_RD_PEND = 1'b1;

  logic [0:0]    stage;
  logic          pend_rd;
  logic          pend_err;
  logic          gnt_q;

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   mem_data [RSP_DEPTH];
  logic          mem_err  [RSP_DEPTH];

  logic          accept;
  logic          in_range;
  logic          inflight;
  logic          fifo_nonempty;
  logic          recv;
  logic          pop;
  logic          pop_mem;
  logic          push_mem;
  logic [31:0]   pend_data;
  logic          gnt_next;

  assign accept   = bus.req && gnt_q;
  assign in_range = (bus.addr & ~(MEM_SIZE - 32'd1)) == MEM_BASE;

  assign sram_cen   = accept && in_range;
  assign sram_wen   = sram_cen && bus.wen;
  assign sram_bwe   = sram_wen ? bus.strb : 4'b0000;
  assign sram_addr  = sram_cen ? bus.addr[AW+1:2] : '0;
  assign sram_wdata = sram_cen ? bus.wdata : 32'h0;

  assign inflight      = (stage == ST_RD_PEND);
  assign fifo_nonempty = (count != '0);
  assign pend_data     = (pend_rd && !pend_err) ? sram_rdata : 32'h0;

  // The in-flight result acts as the FIFO head when the FIFO is empty, which
  // gives the one-cycle accept-to-recv latency without an extra register.
  assign recv    = fifo_nonempty || inflight;
  assign pop     = recv && bus.ack;
  assign pop_mem = pop && fifo_nonempty;
  // A bypassed result that is acked immediately never enters the FIFO.
  assign push_mem = inflight && !(pop && !fifo_nonempty);

  assign count_next = count + CW'(push_mem) - CW'(pop_mem);

  // gnt is the registered credit check for the next cycle, so neither req nor
  // ack reaches gnt combinationally.
  assign gnt_next = (count_next + CW'(accept)) < CW'(RSP_DEPTH);

  assign bus.gnt   = gnt_q;
  assign bus.recv  = recv;
  assign bus.error = fifo_nonempty ? mem_err[rd_ptr] : (inflight && pend_err);
  assign bus.rdata = fifo_nonempty ? mem_data[rd_ptr] : (inflight ? pend_data : 32'h0);

  // Control state: access stage, occupancy, pointers and the grant register.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      stage    <= ST_IDLE;
      pend_rd  <= 1'b0;
      pend_err <= 1'b0;
      gnt_q    <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      stage    <= accept ? ST_RD_PEND : ST_IDLE;
      pend_rd  <= accept && !bus.wen;
      pend_err <= accept && !in_range;
      gnt_q    <= gnt_next;
      count    <= count_next;
      if (push_mem) wr_ptr <= wr_ptr + PW'(1);
      if (pop_mem)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Response storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge g_clk) begin
    if (push_mem) begin
      mem_data[wr_ptr] <= pend_data;
      mem_err[wr_ptr]  <= pend_err;
    end
  end

endmodule
